// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the fetch
// stage and the MEM stage. One requester is granted at a time, the memory-side
// request is registered, read data returns with a one-cycle Done pulse, and a
// watchdog aborts accesses the memory never acknowledges.
//
// Handshake: a requester raises Req with its address/data stable and holds them
// until its Done pulse (Done acts as the single-cycle "ready" that consumes the
// request). On the memory side MemReq/MemWe/MemAddr/MemWdata stay constant from
// grant until the cycle MemAck is seen; MemAck is a one-cycle completion and is
// ignored in any state other than FETCH/DATA.
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic [DATA_W-1:0] IfRdata,
  output logic              IfDone,
  input  logic              DmReq,
  input  logic              DmWe,
  input  logic [ADDR_W-1:0] DmAddr,
  input  logic [DATA_W-1:0] DmWdata,
  output logic [DATA_W-1:0] DmRdata,
  output logic              DmDone,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic              MemAck,
  output logic              PipeStall,
  output logic              BusErr,
  output logic [1:0]        DbgState
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int WD_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [WD_W-1:0]     WD_LIM     = WD_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [STARVE_W-1:0] starve_cnt_q;
  logic [WD_W-1:0]     wd_cnt_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;
  logic                if_done_q;
  logic                dm_done_q;
  logic                bus_err_q;

  // Data wins arbitration unless fetch has been passed over STARVE_MAX times in a row.
  logic grant_data;
  assign grant_data = DmReq && (!IfReq || (starve_cnt_q < STARVE_LIM));

  // Arbitration FSM with registered memory-side request, responses and watchdog.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wd_cnt_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      // Done pulses last exactly the RESP cycle.
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            state_q     <= DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= DmWe;
            mem_addr_q  <= DmAddr;
            mem_wdata_q <= DmWdata;
            // grant_data with IfReq pending implies the counter is below its limit,
            // so this increment saturates at STARVE_MAX.
            if (IfReq) begin
              starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end else if (IfReq) begin
            state_q      <= FETCH;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= IfAddr;
            starve_cnt_q <= '0;
          end
        end
        FETCH, DATA: begin
          if (MemAck) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            wd_cnt_q  <= '0;
            if (state_q == FETCH) begin
              if_rdata_q <= MemRdata;
              if_done_q  <= 1'b1;
            end else begin
              // Stores leave the previous load data visible.
              if (!mem_we_q) begin
                dm_rdata_q <= MemRdata;
              end
              dm_done_q <= 1'b1;
            end
          end else if (wd_cnt_q == WD_LIM) begin
            // Watchdog expiry: complete the access with zero data and flag the bus.
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            wd_cnt_q  <= '0;
            bus_err_q <= 1'b1;
            if (state_q == FETCH) begin
              if_rdata_q <= '0;
              if_done_q  <= 1'b1;
            end else begin
              dm_rdata_q <= '0;
              dm_done_q  <= 1'b1;
            end
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        RESP: begin
          // No grant here, so a requester dropping Req at this edge is never re-served.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IfRdata  = if_rdata_q;
  assign IfDone   = if_done_q;
  assign DmRdata  = dm_rdata_q;
  assign DmDone   = dm_done_q;
  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWdata = mem_wdata_q;
  assign BusErr   = bus_err_q;
  assign DbgState = state_q;

  // Stall the pipeline while either stage has a request that has not completed.
  assign PipeStall = (IfReq && !IfDone) || (DmReq && !DmDone);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.
module tb_mem_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic              Clk;
  logic              Reset;
  logic              IfReq;
  logic [ADDR_W-1:0] IfAddr;
  logic [DATA_W-1:0] IfRdata;
  logic              IfDone;
  logic              DmReq;
  logic              DmWe;
  logic [ADDR_W-1:0] DmAddr;
  logic [DATA_W-1:0] DmWdata;
  logic [DATA_W-1:0] DmRdata;
  logic              DmDone;
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic              MemAck;
  logic              PipeStall;
  logic              BusErr;
  logic [1:0]        DbgState;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mem_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(4), .ACK_TIMEOUT(16)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfRdata(IfRdata), .IfDone(IfDone),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWdata(DmWdata),
    .DmRdata(DmRdata), .DmDone(DmDone),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck),
    .PipeStall(PipeStall), .BusErr(BusErr), .DbgState(DbgState)
  );

  // Clock and global time bound
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; IfReq = 1'b1; IfAddr = 32'h40;
    step(); step();
    chk_cnt++; if (MemReq !== 1'b0) $display("FAIL reset_memreq: got %0b want 0", MemReq); else pass_cnt++;
    chk_cnt++; if (BusErr !== 1'b0) $display("FAIL reset_buserr: got %0b want 0", BusErr); else pass_cnt++;
    chk_cnt++; if ({IfDone, DmDone} !== 2'b00) $display("FAIL reset_done: got %b want 00", {IfDone, DmDone}); else pass_cnt++;
    chk_cnt++; if (DbgState !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", DbgState, S_IDLE); else pass_cnt++;
    chk_cnt++; if ({IfRdata, DmRdata, MemAddr, MemWdata} !== 128'h0) $display("FAIL reset_data: got %h want 0", {IfRdata, DmRdata, MemAddr, MemWdata}); else pass_cnt++;
    Reset = 1'b0;
    step();
    chk_cnt++; if (MemReq !== 1'b1) $display("FAIL reset_first_req: got %0b want 1", MemReq); else pass_cnt++;
    chk_cnt++; if (MemAddr !== 32'h40) $display("FAIL reset_first_addr: got %h want 00000040", MemAddr); else pass_cnt++;
    // Abandon this fetch with another reset so the next test starts clean.
    IfReq = 1'b0; Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    IfReq = 1'b1; IfAddr = 32'h40;
    step();
    chk_cnt++; if (DbgState !== S_FETCH) $display("FAIL fetch_state: got %0d want %0d", DbgState, S_FETCH); else pass_cnt++;
    chk_cnt++; if ({MemReq, MemWe, MemAddr} !== {1'b1, 1'b0, 32'h40}) $display("FAIL fetch_mem: got %b/%b/%h want 1/0/00000040", MemReq, MemWe, MemAddr); else pass_cnt++;
    chk_cnt++; if (PipeStall !== 1'b1) $display("FAIL fetch_stall: got %0b want 1", PipeStall); else pass_cnt++;
    step();
    chk_cnt++; if ({MemReq, IfDone} !== 2'b10) $display("FAIL fetch_wait: got %b want 10", {MemReq, IfDone}); else pass_cnt++;
    MemAck = 1'b1; MemRdata = 32'h8C220004;
    step();
    MemAck = 1'b0; MemRdata = 32'h0;
    chk_cnt++; if (IfDone !== 1'b1) $display("FAIL fetch_done: got %0b want 1", IfDone); else pass_cnt++;
    chk_cnt++; if (IfRdata !== 32'h8C220004) $display("FAIL fetch_rdata: got %h want 8c220004", IfRdata); else pass_cnt++;
    chk_cnt++; if (MemReq !== 1'b0) $display("FAIL fetch_memreq_drop: got %0b want 0", MemReq); else pass_cnt++;
    chk_cnt++; if (DmDone !== 1'b0) $display("FAIL fetch_no_dmdone: got %0b want 0", DmDone); else pass_cnt++;
    IfReq = 1'b0;
    step();
    chk_cnt++; if ({IfDone, PipeStall} !== 2'b00) $display("FAIL fetch_after: got %b want 00", {IfDone, PipeStall}); else pass_cnt++;
    chk_cnt++; if (DbgState !== S_IDLE) $display("FAIL fetch_idle: got %0d want %0d", DbgState, S_IDLE); else pass_cnt++;
    chk_cnt++; if (IfRdata !== 32'h8C220004) $display("FAIL fetch_rdata_hold: got %h want 8c220004", IfRdata); else pass_cnt++;
  endtask

  // Both requesters held, zero-wait memory: expect D,D,D,D,F then D again
  // (the fetch grant clears the starvation count).
  task automatic test_contention();
    bit               exp_fetch [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]       exp_state;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] rd;
    IfReq = 1'b1; IfAddr = 32'h80;
    DmReq = 1'b1; DmWe = 1'b0; DmAddr = 32'h200; DmWdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      exp_state = exp_fetch[i] ? S_FETCH : S_DATA;
      exp_addr  = exp_fetch[i] ? 32'h80 : 32'h200;
      rd        = 32'h1000_0000 + 32'(i);
      step();
      chk_cnt++; if (DbgState !== exp_state) $display("FAIL cont_grant%0d: got state %0d want %0d", i, DbgState, exp_state); else pass_cnt++;
      chk_cnt++; if (MemAddr !== exp_addr) $display("FAIL cont_addr%0d: got %h want %h", i, MemAddr, exp_addr); else pass_cnt++;
      MemAck = 1'b1; MemRdata = rd;
      step();
      MemAck = 1'b0; MemRdata = 32'h0;
      if (exp_fetch[i]) begin
        chk_cnt++; if ({IfDone, DmDone, IfRdata} !== {2'b10, rd}) $display("FAIL cont_resp%0d: got %b%b/%h want 10/%h", i, IfDone, DmDone, IfRdata, rd); else pass_cnt++;
      end else begin
        chk_cnt++; if ({IfDone, DmDone, DmRdata} !== {2'b01, rd}) $display("FAIL cont_resp%0d: got %b%b/%h want 01/%h", i, IfDone, DmDone, DmRdata, rd); else pass_cnt++;
      end
      if (i == 5) begin
        IfReq = 1'b0; DmReq = 1'b0;
      end
      step();
    end
    chk_cnt++; if ({DbgState, MemReq} !== {S_IDLE, 1'b0}) $display("FAIL cont_idle: got %0d/%0b want 0/0", DbgState, MemReq); else pass_cnt++;
  endtask

  task automatic test_store();
    DmReq = 1'b1; DmWe = 1'b1; DmAddr = 32'h100; DmWdata = 32'hDEADBEEF;
    step();
    chk_cnt++; if ({MemReq, MemWe} !== 2'b11) $display("FAIL store_req_we: got %b want 11", {MemReq, MemWe}); else pass_cnt++;
    chk_cnt++; if (MemAddr !== 32'h100) $display("FAIL store_addr: got %h want 00000100", MemAddr); else pass_cnt++;
    chk_cnt++; if (MemWdata !== 32'hDEADBEEF) $display("FAIL store_wdata: got %h want deadbeef", MemWdata); else pass_cnt++;
    MemAck = 1'b1; MemRdata = 32'h55555555;
    step();
    MemAck = 1'b0; MemRdata = 32'h0;
    chk_cnt++; if (DmDone !== 1'b1) $display("FAIL store_done: got %0b want 1", DmDone); else pass_cnt++;
    chk_cnt++; if (DmRdata !== 32'h10000005) $display("FAIL store_rdata_keep: got %h want 10000005", DmRdata); else pass_cnt++;
    DmReq = 1'b0; DmWe = 1'b0;
    step();
    chk_cnt++; if ({MemAddr, MemWdata} !== {32'h100, 32'hDEADBEEF}) $display("FAIL store_hold: got %h/%h want 00000100/deadbeef", MemAddr, MemWdata); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int bad = 0;
    DmReq = 1'b1; DmWe = 1'b0; DmAddr = 32'h300;
    step();
    chk_cnt++; if (BusErr !== 1'b0) $display("FAIL timeout_pre_buserr: got %0b want 0", BusErr); else pass_cnt++;
    // Sixteen cycles in DATA with no ack and no completion.
    for (int i = 0; i < 16; i++) begin
      if (DbgState !== S_DATA || DmDone !== 1'b0 || MemReq !== 1'b1) bad++;
      if (i < 15) step();
    end
    chk_cnt++; if (bad != 0) $display("FAIL timeout_wait: got %0d bad cycles want 0", bad); else pass_cnt++;
    step();
    chk_cnt++; if (DmDone !== 1'b1) $display("FAIL timeout_done: got %0b want 1", DmDone); else pass_cnt++;
    chk_cnt++; if (DmRdata !== 32'h0) $display("FAIL timeout_rdata: got %h want 00000000", DmRdata); else pass_cnt++;
    chk_cnt++; if ({BusErr, MemReq} !== 2'b10) $display("FAIL timeout_buserr: got %b want 10", {BusErr, MemReq}); else pass_cnt++;
    DmReq = 1'b0;
    step(); step(); step();
    chk_cnt++; if ({BusErr, DmDone, DbgState} !== {2'b10, S_IDLE}) $display("FAIL timeout_sticky: got %b want 1000", {BusErr, DmDone, DbgState}); else pass_cnt++;
  endtask

  task automatic test_midop_reset();
    DmReq = 1'b1; DmWe = 1'b0; DmAddr = 32'h400;
    step();
    chk_cnt++; if ({DbgState, MemReq} !== {S_DATA, 1'b1}) $display("FAIL midrst_grant: got %0d/%0b want 2/1", DbgState, MemReq); else pass_cnt++;
    Reset = 1'b1;
    step();
    Reset = 1'b0; DmReq = 1'b0; MemAck = 1'b1; MemRdata = 32'hABCD;
    step();
    MemAck = 1'b0; MemRdata = 32'h0;
    chk_cnt++; if (DmDone !== 1'b0) $display("FAIL midrst_no_done: got %0b want 0", DmDone); else pass_cnt++;
    chk_cnt++; if ({DbgState, MemReq} !== {S_IDLE, 1'b0}) $display("FAIL midrst_idle: got %0d/%0b want 0/0", DbgState, MemReq); else pass_cnt++;
    chk_cnt++; if ({DmRdata, BusErr} !== 33'h0) $display("FAIL midrst_cleared: got %h/%0b want 0/0", DmRdata, BusErr); else pass_cnt++;
    step();
    chk_cnt++; if ({DmDone, MemReq} !== 2'b00) $display("FAIL midrst_after: got %b want 00", {DmDone, MemReq}); else pass_cnt++;
  endtask

  // Test sequence and final report
  initial begin
    Reset = 1'b1; IfReq = 1'b0; IfAddr = '0;
    DmReq = 1'b0; DmWe = 1'b0; DmAddr = '0; DmWdata = '0;
    MemRdata = '0; MemAck = 1'b0;
    #1;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_timeout();
    test_midop_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
